// File: rtl/systolic_pe_if.sv
// Operand/result bundle between a systolic PE and its neighbours.
// Master drives operands, slave (the PE) returns registered values.
interface systolic_pe_if #(
    parameter int DATA_W = 16
);
    logic                     weight_en;
    logic signed [DATA_W-1:0] activation_in;
    logic signed [DATA_W-1:0] weight_in;
    logic signed [DATA_W-1:0] partial_sum_in;
    logic signed [DATA_W-1:0] reg_activation;
    logic signed [DATA_W-1:0] reg_weight;
    logic signed [DATA_W-1:0] reg_partial_sum;

    modport master (
        output weight_en,
        output activation_in,
        output weight_in,
        output partial_sum_in,
        input  reg_activation,
        input  reg_weight,
        input  reg_partial_sum
    );

    modport slave (
        input  weight_en,
        input  activation_in,
        input  weight_in,
        input  partial_sum_in,
        output reg_activation,
        output reg_weight,
        output reg_partial_sum
    );
endinterface

// File: rtl/systolic_pe.sv
// Weight-stationary systolic PE: fixed-point MAC with a stored weight,
// one-cycle latency, forwarding activation and weight to neighbours.
module systolic_pe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 10,
    parameter int SAT_EN = 0
) (
    input  logic           clk,
    input  logic           rst,
    systolic_pe_if.slave   pe
);
    localparam logic signed [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0]   act_q, act_d;
    logic signed [DATA_W-1:0]   w_q, w_d;
    logic signed [DATA_W-1:0]   psum_q, psum_d;
    logic signed [DATA_W-1:0]   w_eff;
    logic signed [DATA_W-1:0]   scaled;
    logic signed [2*DATA_W-1:0] prod;
    logic        [DATA_W:0]     sum_ext;
    logic                       ovf;
    logic                       unused_prod;

    always_comb begin
        w_eff = pe.weight_en ? pe.weight_in : w_q;
        prod  = $signed({{DATA_W{pe.activation_in[DATA_W-1]}}, pe.activation_in})
              * $signed({{DATA_W{w_eff[DATA_W-1]}}, w_eff});
        // Dropping the low FRAC_W bits floors toward -inf.
        scaled  = prod[FRAC_W+DATA_W-1:FRAC_W];
        sum_ext = {pe.partial_sum_in[DATA_W-1], pe.partial_sum_in}
                + {scaled[DATA_W-1], scaled};
        ovf     = sum_ext[DATA_W] != sum_ext[DATA_W-1];
    end

    assign unused_prod = ^prod;

    always_comb begin
        act_d  = pe.activation_in;
        w_d    = w_eff;
        psum_d = sum_ext[DATA_W-1:0];
        if (SAT_EN != 0 && ovf) begin
            psum_d = sum_ext[DATA_W] ? MinVal : MaxVal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            act_q  <= '0;
            w_q    <= '0;
            psum_q <= '0;
        end else begin
            act_q  <= act_d;
            w_q    <= w_d;
            psum_q <= psum_d;
        end
    end

    assign pe.reg_activation  = act_q;
    assign pe.reg_weight      = w_q;
    assign pe.reg_partial_sum = psum_q;
endmodule

// File: tb/tb_systolic_pe.sv
// Random and directed checks of systolic_pe (wrap and saturating builds)
// against an integer-arithmetic reference model.
module tb_systolic_pe;
    localparam int DW = 16;
    localparam int FW = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    systolic_pe_if #(.DATA_W(DW)) ifw ();
    systolic_pe_if #(.DATA_W(DW)) ifs ();

    systolic_pe #(.DATA_W(DW), .FRAC_W(FW), .SAT_EN(0)) dut_w (
        .clk (clk),
        .rst (rst),
        .pe  (ifw)
    );

    systolic_pe #(.DATA_W(DW), .FRAC_W(FW), .SAT_EN(1)) dut_s (
        .clk (clk),
        .rst (rst),
        .pe  (ifs)
    );

    int checks   = 0;
    int failures = 0;

    logic signed [DW-1:0] m_w;
    logic signed [DW-1:0] m_act;
    logic signed [DW-1:0] m_pw;
    logic signed [DW-1:0] m_ps;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference MAC: real-valued product floored to the fixed-point grid.
    function automatic logic signed [DW-1:0] ref_mac(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] w,
        input logic signed [DW-1:0] ps,
        input bit sat
    );
        longint p;
        longint q;
        longint s;
        logic signed [DW-1:0] sc;
        p  = longint'(a) * longint'(w);
        q  = p >>> FW;
        sc = q[DW-1:0];
        s  = longint'(ps) + longint'(sc);
        if (sat && s > 32767)  s = 32767;
        if (sat && s < -32768) s = -32768;
        return s[DW-1:0];
    endfunction

    task automatic cycle(input logic r, input logic we,
                         input logic [DW-1:0] a, input logic [DW-1:0] w,
                         input logic [DW-1:0] ps, input string tag);
        logic signed [DW-1:0] weff;
        rst                = r;
        ifw.weight_en      = we;
        ifw.activation_in  = a;
        ifw.weight_in      = w;
        ifw.partial_sum_in = ps;
        ifs.weight_en      = we;
        ifs.activation_in  = a;
        ifs.weight_in      = w;
        ifs.partial_sum_in = ps;
        @(posedge clk);
        if (!r) begin
            m_w   = '0;
            m_act = '0;
            m_pw  = '0;
            m_ps  = '0;
        end else begin
            weff  = we ? w : m_w;
            m_pw  = ref_mac(a, weff, ps, 1'b0);
            m_ps  = ref_mac(a, weff, ps, 1'b1);
            m_act = a;
            if (we) m_w = w;
        end
        #1;
        chk({tag, ".wrap.act"}, ifw.reg_activation, m_act);
        chk({tag, ".wrap.w"}, ifw.reg_weight, m_w);
        chk({tag, ".wrap.ps"}, ifw.reg_partial_sum, m_pw);
        chk({tag, ".sat.act"}, ifs.reg_activation, m_act);
        chk({tag, ".sat.w"}, ifs.reg_weight, m_w);
        chk({tag, ".sat.ps"}, ifs.reg_partial_sum, m_ps);
    endtask

    initial begin
        m_w = '0; m_act = '0; m_pw = '0; m_ps = '0;
        cycle(1'b0, 1'b1, 16'h1234, 16'h5678, 16'h4321, "reset");
        cycle(1'b1, 1'b1, 16'h0400, 16'h0800, 16'h0000, "load2x1");
        chk("load2x1.const", ifw.reg_partial_sum, 16'h0800);
        cycle(1'b1, 1'b1, 16'h0000, 16'h0200, 16'h0000, "ldw");
        cycle(1'b1, 1'b0, 16'hFC00, 16'h7777, 16'h0100, "hold");
        chk("hold.const", ifw.reg_partial_sum, 16'hFF00);
        chk("hold.wconst", ifw.reg_weight, 16'h0200);
        cycle(1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, "floor");
        chk("floor.const", ifw.reg_partial_sum, 16'hFFFF);
        cycle(1'b1, 1'b1, 16'h0400, 16'h0400, 16'h7FFF, "ovfpos");
        chk("ovfpos.wrap", ifw.reg_partial_sum, 16'h83FF);
        chk("ovfpos.sat", ifs.reg_partial_sum, 16'h7FFF);
        cycle(1'b1, 1'b1, 16'hFC00, 16'h0400, 16'h8000, "ovfneg");
        chk("ovfneg.sat", ifs.reg_partial_sum, 16'h8000);
        cycle(1'b1, 1'b1, 16'h0400, 16'h0C00, 16'h0000, "ldmid");
        cycle(1'b0, 1'b0, 16'h0400, 16'h0000, 16'h0000, "midrst");
        cycle(1'b1, 1'b0, 16'h7FFF, 16'h1111, 16'h0123, "zerow");
        chk("zerow.const", ifw.reg_partial_sum, 16'h0123);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'h0000, "stream");
        end
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0),
                  16'($urandom), 16'($urandom), 16'($urandom), "rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
